// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counter BHT, BTB and mispredict statistics.
// Lookup is combinational in IF. Training and redirect come from the EX-resolved branch.
module branch_predictor #(
    parameter int DATAW   = 32,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DATAW-1:0] if_pc,
    output logic             if_pred_taken,
    output logic [DATAW-1:0] if_pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic [DATAW-1:0] ex_pc,
    input  logic             ex_taken,
    input  logic [DATAW-1:0] ex_target,
    input  logic             ex_pred_taken,
    input  logic [DATAW-1:0] ex_pred_target,
    output logic             redirect,
    output logic [DATAW-1:0] redirect_pc,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = DATAW - IDXW - 2;

    logic             r_valid  [ENTRIES];
    logic [TAGW-1:0]  r_tag    [ENTRIES];
    logic [DATAW-1:0] r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_stat_br;
    logic [31:0]      r_stat_mis;

    logic [IDXW-1:0]  w_if_idx;
    logic [IDXW-1:0]  w_ex_idx;
    logic [TAGW-1:0]  w_if_tag;
    logic [TAGW-1:0]  w_ex_tag;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic             w_upd;
    logic             w_redirect;
    logic             w_unused_pcbits;

    assign w_if_idx = if_pc[IDXW+1:2];
    assign w_if_tag = if_pc[DATAW-1:IDXW+2];
    assign w_ex_idx = ex_pc[IDXW+1:2];
    assign w_ex_tag = ex_pc[DATAW-1:IDXW+2];
    assign w_unused_pcbits = ^if_pc[1:0];

    assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign if_pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign if_pred_target = if_pred_taken ? r_target[w_if_idx] : '0;

    assign w_upd      = ex_valid && ex_is_br;
    assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_redirect = w_upd && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_pred_target != ex_target)));

    assign redirect    = w_redirect;
    assign redirect_pc = !w_redirect ? '0 :
                         ex_taken    ? ex_target : ex_pc + DATAW'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                if (ex_taken) begin
                    if (r_ctr[w_ex_idx] != 2'b11)
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                    r_target[w_ex_idx] <= ex_target;
                end else if (r_ctr[w_ex_idx] != 2'b00) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                // Miss on a taken branch evicts whatever occupied the slot.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_upd && (r_stat_br != '1))
                r_stat_br <= r_stat_br + 32'd1;
            if (w_redirect && (r_stat_mis != '1))
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against an array-based behavioural model.
module tb_branch_predictor;
    localparam int DATAW   = 32;
    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.DATAW(DATAW), .ENTRIES(ENTRIES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .if_pred_target  (if_pred_target),
        .ex_valid        (ex_valid),
        .ex_is_br        (ex_is_br),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ex_pred_taken   (ex_pred_taken),
        .ex_pred_target  (ex_pred_target),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: per-slot record, counter kept as a plain integer 0..3.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] ptag(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == ptag(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[slot(pc)] : 32'h0;
    endfunction

    // Inputs are already driven (just after a posedge); check at the negedge,
    // then let the next posedge commit and advance the model.
    task automatic step();
        bit          upd;
        bit          red;
        logic [31:0] rpc;
        int          s;
        @(negedge clk);
        upd = ex_valid && ex_is_br;
        red = upd && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target));
        rpc = !red ? 32'h0 : (ex_taken ? ex_target : ex_pc + 32'd4);
        check("pred_taken",  if_pred_taken,    m_pred(if_pc));
        check("pred_target", if_pred_target,   m_pred_tgt(if_pc));
        check("redirect",    redirect,         red);
        check("redirect_pc", redirect_pc,      rpc);
        check("stat_br",     stat_branches,    m_br);
        check("stat_mis",    stat_mispredicts, m_mis);
        @(posedge clk);
        if (upd) begin
            s = slot(ex_pc);
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = ex_target;
                end else begin
                    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (ex_taken) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = ptag(ex_pc);
                m_tgt[s]   = ex_target;
                m_ctr[s]   = 2;
            end
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (red && m_mis != 32'hFFFF_FFFF) m_mis++;
        end
        #1;
    endtask

    task automatic br(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        if_pc = pc;
        step();
    endtask

    task automatic peek(input string tag, input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        ex_valid = 1'b0; ex_is_br = 1'b0; if_pc = pc;
        @(negedge clk);
        check({tag, "_taken"},  if_pred_taken,  tk);
        check({tag, "_target"}, if_pred_target, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int n);
        logic [31:0] pc;
        for (int k = 0; k < n; k++) begin
            pc = (32'($urandom_range(0, 63)) << 2) + 32'h1000 * $urandom_range(0, 1)
                 + $urandom_range(0, 3);
            ex_valid  = ($urandom_range(0, 7) != 0);
            ex_is_br  = ($urandom_range(0, 3) != 0);
            ex_pc     = pc;
            ex_taken  = $urandom_range(0, 1) == 1;
            ex_target = 32'($urandom_range(0, 7)) << 4;
            ex_pred_taken  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1) : m_pred(pc);
            ex_pred_target = ($urandom_range(0, 1) == 1) ? m_pred_tgt(pc) : ex_target;
            if_pc = ($urandom_range(0, 1) == 1) ? pc :
                    (32'($urandom_range(0, 63)) << 2) + 32'h1000 * $urandom_range(0, 1);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_is_br = 1'b0; ex_pc = 0; ex_taken = 1'b0;
        ex_target = 0; ex_pred_taken = 1'b0; ex_pred_target = 0; if_pc = 32'h100;
        m_reset();
        #12;
        check("rst_taken",  if_pred_taken,    1'b0);
        check("rst_target", if_pred_target,   32'h0);
        check("rst_br",     stat_branches,    32'h0);
        check("rst_mis",    stat_mispredicts, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        br(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        peek("alloc", 32'h100, 1'b1, 32'h80);
        check("alloc_br",  stat_branches,    32'd1);
        check("alloc_mis", stat_mispredicts, 32'd1);

        br(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        peek("nt1", 32'h100, 1'b0, 32'h0);
        br(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        br(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        br(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        peek("t1", 32'h100, 1'b0, 32'h0);
        br(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        peek("t2", 32'h100, 1'b1, 32'h80);

        br(32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
        peek("alias_old", 32'h100, 1'b0, 32'h0);
        peek("alias_new", 32'h140, 1'b1, 32'h200);
        br(32'h180, 1'b0, 32'h0, 1'b0, 32'h0);
        peek("alias_keep", 32'h140, 1'b1, 32'h200);

        br(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        br(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        peek("wrongtgt", 32'h100, 1'b1, 32'h90);

        br(32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b1, 32'h1234);

        ex_valid = 1'b1; ex_is_br = 1'b0; ex_pc = 32'h100; ex_taken = 1'b1;
        ex_target = 32'h300; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        step();

        random_phase(400);

        // Asynchronous reset landing while an allocating update is presented.
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h1100; ex_taken = 1'b1;
        ex_target = 32'h440; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        if_pc = 32'h100;
        #2 rst_n = 1'b0;
        #1;
        check("async_taken", if_pred_taken,    1'b0);
        check("async_br",    stat_branches,    32'h0);
        check("async_mis",   stat_mispredicts, 32'h0);
        check("async_redir", redirect,         1'b1);
        m_reset();
        @(posedge clk);
        ex_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        peek("lost_upd", 32'h1100, 1'b0, 32'h0);
        check("post_rst_br", stat_branches, 32'h0);

        random_phase(150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
